// File: rtl/seq_detector_param_if.sv
// rtl/seq_detector_param_if.sv - serial data, configuration and match-status bundle for seq_detector_param
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               din;
    logic               din_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clear;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cnt_sat;
    logic               cfg_err;

    modport master (
        output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clear,
        input  match, match_count, cnt_sat, cfg_err
    );

    modport slave (
        input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clear,
        output match, match_count, cnt_sat, cfg_err
    );
endinterface

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial pattern detector with overlap mode and saturating match counter
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1100,
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b0
) (
    input logic              clk,
    input logic              rst,
    seq_detector_param_if.slave bus
);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;
    logic               r_sat;
    logic               r_err;

    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;
    logic               w_count_hit;
    logic               w_cfg_ok;
    logic [CNT_W-1:0]   w_count_n;

    assign w_hist_n = {r_hist[MAX_LEN-2:0], bus.din};
    assign w_fill_n = (r_fill == MAX_LEN_V) ? r_fill : r_fill + LEN_W'(1);
    // Shifting by the full width yields zero, so len == MAX_LEN gives an all-ones mask.
    assign w_mask   = ~({MAX_LEN{1'b1}} << r_len);
    assign w_hit    = (w_fill_n >= r_len) && ((w_hist_n & w_mask) == (r_pattern & w_mask));
    assign w_count_hit = w_hit && bus.din_valid && !bus.cfg_load;
    assign w_cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_V);

    always_comb begin
        w_count_n = r_count;
        if (bus.cnt_clear) begin
            w_count_n = {{(CNT_W-1){1'b0}}, w_count_hit};
        end else if (w_count_hit && (r_count != CNT_MAX)) begin
            w_count_n = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= RST_PATTERN;
            r_len     <= LEN_W'(RST_LEN);
            r_overlap <= RST_OVERLAP;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_sat     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (bus.cfg_load) begin
                r_fill <= '0;
                if (w_cfg_ok) begin
                    r_pattern <= bus.cfg_pattern;
                    r_len     <= bus.cfg_len;
                    r_overlap <= bus.cfg_overlap;
                    r_err     <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (bus.din_valid) begin
                r_hist  <= w_hist_n;
                r_match <= w_hit;
                // Non-overlapping: retained bits must not seed the next match.
                r_fill  <= (w_hit && !r_overlap) ? '0 : w_fill_n;
            end
            r_count <= w_count_n;
            r_sat   <= (w_count_n == CNT_MAX);
        end
    end

    assign bus.match       = r_match;
    assign bus.match_count = r_count;
    assign bus.cnt_sat     = r_sat;
    assign bus.cfg_err     = r_err;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param
module tb_seq_detector_param;
    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus();

    seq_detector_param #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
        .RST_PATTERN(8'b0000_1100), .RST_LEN(4), .RST_OVERLAP(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        match;
        logic [31:0] count;
        logic        sat;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    bit         mq[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    int         m_cnt;
    bit         m_err;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pat = 8'b0000_1100;
        m_len = 4;
        m_ov  = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    // Drives one cycle, then records what the outputs must show after that edge.
    task automatic step(bit d, bit v, bit ld = 0, logic [7:0] pat = 8'h00,
                        int len = 0, bit ov = 0, bit clr = 0);
        bit   hit;
        exp_t e;
        bus.din         = d;
        bus.din_valid   = v;
        bus.cfg_load    = ld;
        bus.cfg_pattern = pat;
        bus.cfg_len     = LEN_W'(len);
        bus.cfg_overlap = ov;
        bus.cnt_clear   = clr;
        @(posedge clk);
        hit = 1'b0;
        if (ld) begin
            mq.delete();
            if (len >= 1 && len <= MAX_LEN) begin
                m_pat = pat;
                m_len = len;
                m_ov  = ov;
                m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (v) begin
            mq.push_back(d);
            if (mq.size() > MAX_LEN) void'(mq.pop_front());
            if (mq.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (mq[mq.size()-1-k] != m_pat[k]) hit = 1'b0;
            end
            if (hit && !m_ov) mq.delete();
        end
        if (clr) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt++;
        e.match = hit;
        e.count = m_cnt;
        e.sat   = (m_cnt == CNT_MAX);
        e.err   = m_err;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic send(logic [15:0] bits, int n);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) step(b[i], 1'b1);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("match", 32'(bus.match), 32'(e.match));
                chk("match_count", 32'(bus.match_count), e.count);
                chk("cnt_sat", 32'(bus.cnt_sat), 32'(e.sat));
                chk("cfg_err", 32'(bus.cfg_err), 32'(e.err));
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        bus.din = 0; bus.din_valid = 0; bus.cfg_load = 0; bus.cfg_pattern = '0;
        bus.cfg_len = '0; bus.cfg_overlap = 0; bus.cnt_clear = 0;
        model_reset();
        #12;
        chk("reset_match", 32'(bus.match), 0);
        chk("reset_count", 32'(bus.match_count), 0);
        chk("reset_sat", 32'(bus.cnt_sat), 0);
        chk("reset_err", 32'(bus.cfg_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(16'b1100_1100, 8);

        step(0, 0, 1, 8'b101, 3, 1);
        send(16'b10101, 5);
        step(0, 0, 1, 8'b101, 3, 0);
        step(0, 0, 0, 8'h00, 0, 0, 1);
        send(16'b10101, 5);

        step(0, 0, 1, 8'b1100, 4, 0);
        send(16'b11, 2); idle(3); send(16'b00, 2);
        send(16'b11, 2);
        step(0, 0, 1, 8'b1100, 4, 0);
        send(16'b00, 2);

        step(0, 0, 1, 8'b1, 1, 0);
        step(0, 0, 0, 8'h00, 0, 0, 1);
        send(16'b111111, 6);
        step(1, 1, 0, 8'h00, 0, 0, 1);

        step(0, 0, 1, 8'b0110, 4, 0);
        step(0, 0, 1, 8'b1, 0, 0);
        send(16'b0110, 4);
        step(0, 0, 1, 8'b11, 9, 1);
        send(16'b0110, 4);
        step(0, 0, 1, 8'b1100, 4, 0);

        send(16'b110, 3);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async_match", 32'(bus.match), 0);
        chk("async_count", 32'(bus.match_count), 0);
        chk("async_sat", 32'(bus.cnt_sat), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        send(16'b0, 1);
        send(16'b1100, 4);

        for (int i = 0; i < 400; i++) begin
            bit         d, v, ld, ov, clr;
            logic [7:0] pat;
            int         len;
            d   = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 24) == 0);
            pat = 8'($urandom);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(1, 4));
            ov  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 19) == 0);
            step(d, v, ld, pat, len, ov, clr);
        end

        idle(1);
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
